// File: rtl/stack_calc_ctrl.sv
// stack_calc_ctrl
//   Stack-calculator controller. Executes PUSH/POP/ADD/SUB/TOP/CLEAR/INC/DEC on a
//   descending stack held in an external single-port RAM with 1-cycle read
//   latency, and drives the DAR/DVR display registers.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for op_valid; rejects, POP-to-empty and CLEAR finish here
//   WR    | RAM write: PUSH operand, or ADD/SUB result into second slot
//   RD1   | ADD/SUB: read top (SP+1)
//   RD2   | ADD/SUB: read second (SP+2), capture top as A
//   RDV   | POP/TOP/INC/DEC: read the word to be displayed
//   CAP   | capture read data into DVR
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   op_valid, op, sw_data op request (sampled in IDLE only) and PUSH operand
//   mem_cs/we/addr/wdata  RAM control and write data; mem_rdata read data
//   dar, dvr              display address / value registers
//   stack_cnt,empty,full  stack occupancy
//   busy, err             FSM not IDLE; sticky rejection flag
module stack_calc_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] sw_data,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] dar,
  output logic [DATA_W-1:0] dvr,
  output logic [ADDR_W:0]   stack_cnt,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_TOP   = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;
  localparam logic [2:0] OP_INC   = 3'd6;
  localparam logic [2:0] OP_DEC   = 3'd7;

  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TWO    = ADDR_W'(2);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD1, S_RD2, S_RDV, S_CAP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   dar_q, dar_d;
  logic [DATA_W-1:0]   dvr_q, dvr_d;
  logic                err_q, err_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   a_q, a_d;

  logic [DATA_W:0]     sum_w, dif_w;
  logic [DATA_W-1:0]   res_w;

  // A is the top word (captured in RD2); B is the second word arriving in WR.
  assign sum_w = {1'b0, a_q} + {1'b0, mem_rdata};
  assign dif_w = {1'b0, a_q} - {1'b0, mem_rdata};

  always_comb begin
    res_w = sum_w[DATA_W-1:0];
    if (op_q == OP_SUB) begin
      res_w = dif_w[DATA_W-1:0];
      if ((SAT != 0) && dif_w[DATA_W]) res_w = '0;
    end else if ((SAT != 0) && sum_w[DATA_W]) begin
      res_w = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sp_q    <= '1;
      cnt_q   <= '0;
      dar_q   <= '0;
      dvr_q   <= '0;
      err_q   <= 1'b0;
      op_q    <= OP_PUSH;
      opnd_q  <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      dar_q   <= dar_d;
      dvr_q   <= dvr_d;
      err_q   <= err_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    dar_d     = dar_q;
    dvr_d     = dvr_q;
    err_d     = err_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_PUSH: begin
              if (cnt_q == CNT_FULL) err_d = 1'b1;
              else begin
                err_d   = 1'b0;
                op_d    = op;
                opnd_d  = sw_data;
                state_d = S_WR;
              end
            end
            OP_POP: begin
              if (cnt_q == '0) err_d = 1'b1;
              else begin
                err_d = 1'b0;
                op_d  = op;
                sp_d  = sp_q + A_ONE;
                cnt_d = cnt_q - CNT_ONE;
                // Popping the last word leaves nothing to display.
                if (cnt_q == CNT_ONE) begin
                  dar_d = '0;
                  dvr_d = '0;
                end else begin
                  state_d = S_RDV;
                end
              end
            end
            OP_ADD, OP_SUB: begin
              if (cnt_q < CNT_TWO) err_d = 1'b1;
              else begin
                err_d   = 1'b0;
                op_d    = op;
                state_d = S_RD1;
              end
            end
            OP_TOP: begin
              if (cnt_q == '0) err_d = 1'b1;
              else begin
                err_d   = 1'b0;
                op_d    = op;
                dar_d   = sp_q + A_ONE;
                state_d = S_RDV;
              end
            end
            OP_CLEAR: begin
              sp_d  = '1;
              cnt_d = '0;
              dar_d = '0;
              dvr_d = '0;
              err_d = 1'b0;
            end
            OP_INC: begin
              err_d   = 1'b0;
              op_d    = op;
              dar_d   = dar_q + A_ONE;
              state_d = S_RDV;
            end
            default: begin // OP_DEC
              err_d   = 1'b0;
              op_d    = op;
              dar_d   = dar_q - A_ONE;
              state_d = S_RDV;
            end
          endcase
        end
      end
      S_WR: begin
        mem_cs  = 1'b1;
        mem_we  = 1'b1;
        state_d = S_IDLE;
        if (op_q == OP_PUSH) begin
          mem_addr  = sp_q;
          mem_wdata = opnd_q;
          sp_d      = sp_q - A_ONE;
          cnt_d     = cnt_q + CNT_ONE;
          dar_d     = sp_q;
          dvr_d     = opnd_q;
        end else begin
          // Result replaces the second word; the old top slot becomes free.
          mem_addr  = sp_q + A_TWO;
          mem_wdata = res_w;
          sp_d      = sp_q + A_ONE;
          cnt_d     = cnt_q - CNT_ONE;
          dar_d     = sp_q + A_TWO;
          dvr_d     = res_w;
        end
      end
      S_RD1: begin
        mem_cs   = 1'b1;
        mem_addr = sp_q + A_ONE;
        state_d  = S_RD2;
      end
      S_RD2: begin
        mem_cs   = 1'b1;
        mem_addr = sp_q + A_TWO;
        a_d      = mem_rdata;
        state_d  = S_WR;
      end
      S_RDV: begin
        mem_cs   = 1'b1;
        mem_addr = (op_q == OP_POP) ? (sp_q + A_ONE) : dar_q;
        state_d  = S_CAP;
      end
      S_CAP: begin
        dvr_d = mem_rdata;
        if (op_q == OP_POP) dar_d = sp_q + A_ONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dar       = dar_q;
  assign dvr       = dvr_q;
  assign stack_cnt = cnt_q;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_FULL);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule
